// File: rtl/sm_hex_display_pkg.sv
// Shared types and active-high glyph constants for the hex display scanner.
// Segment bit order is g f e d c b a.
package sm_hex_display_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_0     = 7'h3F;
  localparam seg7_t SEG7_1     = 7'h06;
  localparam seg7_t SEG7_2     = 7'h5B;
  localparam seg7_t SEG7_3     = 7'h4F;
  localparam seg7_t SEG7_4     = 7'h66;
  localparam seg7_t SEG7_5     = 7'h6D;
  localparam seg7_t SEG7_6     = 7'h7D;
  localparam seg7_t SEG7_7     = 7'h07;
  localparam seg7_t SEG7_8     = 7'h7F;
  localparam seg7_t SEG7_9     = 7'h6F;
  localparam seg7_t SEG7_A     = 7'h77;
  localparam seg7_t SEG7_B     = 7'h7C;
  localparam seg7_t SEG7_C     = 7'h39;
  localparam seg7_t SEG7_D     = 7'h5E;
  localparam seg7_t SEG7_E     = 7'h79;
  localparam seg7_t SEG7_F     = 7'h71;
  localparam seg7_t SEG7_BLANK = 7'h00;

endpackage

// File: rtl/sm_hex_seg_decode.sv
// Combinational hex nibble to seven-segment glyph decoder, active-high.
module sm_hex_seg_decode
  import sm_hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      segments
);

  always_comb begin
    segments = SEG7_BLANK;
    case (nibble)
      4'h0: segments = SEG7_0;
      4'h1: segments = SEG7_1;
      4'h2: segments = SEG7_2;
      4'h3: segments = SEG7_3;
      4'h4: segments = SEG7_4;
      4'h5: segments = SEG7_5;
      4'h6: segments = SEG7_6;
      4'h7: segments = SEG7_7;
      4'h8: segments = SEG7_8;
      4'h9: segments = SEG7_9;
      4'hA: segments = SEG7_A;
      4'hB: segments = SEG7_B;
      4'hC: segments = SEG7_C;
      4'hD: segments = SEG7_D;
      4'hE: segments = SEG7_E;
      4'hF: segments = SEG7_F;
      default: segments = SEG7_BLANK;
    endcase
  end

endmodule

// File: rtl/sm_hex_display_scan.sv
// Round-robin multiplexed driver for a bank of seven-segment hex digits with tear-free updates.
// Optional leading-zero blanking is enabled by defining SM_HEX_DISPLAY_SCAN_LZB_EN.
module sm_hex_display_scan
  import sm_hex_display_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int REFRESH_CYCLES = 50000,
  parameter int BLANK_CYCLES   = 4,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   number,
  input  logic                  number_we,
  input  logic [DIGITS-1:0]     dots,
  output seg7_t                 seven_segments,
  output logic                  dot,
  output logic [DIGITS-1:0]     anodes,
  output logic                  frame_start
);

  localparam int CNT_W = $clog2(REFRESH_CYCLES);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic INV = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [4*DIGITS-1:0] shadow_num;
  logic [DIGITS-1:0]   shadow_dots;
  logic [4*DIGITS-1:0] disp_num;
  logic [DIGITS-1:0]   disp_dots;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;

  logic                tick;
  logic                wrap;
  logic [3:0]          cur_nibble;
  logic                cur_dot;
  seg7_t               glyph;
  logic                blanked;
  logic                lit;
  logic [DIGITS-1:0]   anode_on;

  assign tick = enable && (cnt == CNT_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_num  <= '0;
      shadow_dots <= '0;
    end else if (number_we) begin
      shadow_num  <= number;
      shadow_dots <= dots;
    end
  end

  // disp only follows shadow on the frame wrap, so a frame never mixes two values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      disp_num    <= '0;
      disp_dots   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (tick) begin
        cnt <= '0;
        if (wrap) begin
          idx       <= '0;
          disp_num  <= shadow_num;
          disp_dots <= shadow_dots;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end else if (enable) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign cur_nibble = disp_num[{idx, 2'b00} +: 4];
  assign cur_dot    = disp_dots[idx];

  sm_hex_seg_decode u_decode (
    .nibble   (cur_nibble),
    .segments (glyph)
  );

`ifdef SM_HEX_DISPLAY_SCAN_LZB_EN
  logic [IDX_W-1:0] top_digit;

  // Highest non-zero nibble; digit 0 stays visible so zero still reads "0"
  always_comb begin
    top_digit = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (disp_num[4*i +: 4] != 4'h0) top_digit = IDX_W'(i);
    end
    blanked = (idx > top_digit);
  end
`else
  assign blanked = 1'b0;
`endif

  assign lit = enable && (cnt >= CNT_BLANK) && !blanked;

  always_comb begin
    anode_on      = '0;
    anode_on[idx] = lit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seven_segments <= {7{INV}};
      dot            <= INV;
      anodes         <= {DIGITS{INV}};
    end else begin
      seven_segments <= (lit ? glyph : SEG7_BLANK) ^ {7{INV}};
      dot            <= (lit & cur_dot) ^ INV;
      anodes         <= anode_on ^ {DIGITS{INV}};
    end
  end

endmodule

// File: tb/tb_sm_hex_display_scan.sv
// Directed self-checking bench for sm_hex_display_scan (DIGITS=4, REFRESH=4, BLANK=1, active-low).
// Runs the leading-zero test when SM_HEX_DISPLAY_SCAN_LZB_EN is defined, the dots test otherwise.
module tb_sm_hex_display_scan;

  localparam int DIGITS         = 4;
  localparam int REFRESH_CYCLES = 4;
  localparam int BLANK_CYCLES   = 1;
  localparam int ACTIVE_LOW     = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] number;
  logic        number_we;
  logic [3:0]  dots;
  logic [6:0]  seven_segments;
  logic        dot;
  logic [3:0]  anodes;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  sm_hex_display_scan #(
    .DIGITS         (DIGITS),
    .REFRESH_CYCLES (REFRESH_CYCLES),
    .BLANK_CYCLES   (BLANK_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .number         (number),
    .number_we      (number_we),
    .dots           (dots),
    .seven_segments (seven_segments),
    .dot            (dot),
    .anodes         (anodes),
    .frame_start    (frame_start)
  );

  always #5 clk = ~clk;

  // Hand-written active-low glyphs, g f e d c b a
  function automatic logic [6:0] glyph_al(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic wait_frame(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL %s_frame_wait: got no frame_start, need one within 64 cycles", tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; number = '0; number_we = 1'b0; dots = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (anodes !== 4'b1111) begin n_fail++; $display("[TB] FAIL rst_anodes: got %b need 1111", anodes); end
    n_checks++;
    if (seven_segments !== 7'b1111111) begin n_fail++; $display("[TB] FAIL rst_segments: got %b need 1111111", seven_segments); end
    n_checks++;
    if (dot !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_dot: got %b need 1", dot); end
    n_checks++;
    if (frame_start !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_frame_start: got %b need 0", frame_start); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (anodes !== 4'b1111) begin n_fail++; $display("[TB] FAIL rst_cycle1_anodes: got %b need 1111", anodes); end
    @(negedge clk);
    n_checks++;
    if (anodes !== 4'b1110) begin n_fail++; $display("[TB] FAIL rst_cycle2_anodes: got %b need 1110", anodes); end
    n_checks++;
    if (seven_segments !== 7'b1000000) begin n_fail++; $display("[TB] FAIL rst_cycle2_segments: got %b need 1000000", seven_segments); end
  endtask

  task automatic test_scan_order();
    logic [3:0] sel;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int d, c;
    number = 16'h1234; number_we = 1'b1;
    @(negedge clk);
    number_we = 1'b0;
    wait_frame("scan");
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      d = (k - 1) / 4;
      c = (k - 1) % 4;
      sel = 4'b0001 << d;
      exp_an  = (c == 0) ? 4'b1111 : ~sel;
      exp_seg = (c == 0) ? 7'h7F : glyph_al(number[d*4 +: 4]);
      n_checks++;
      if (anodes !== exp_an) begin n_fail++; $display("[TB] FAIL scan_anodes k=%0d: got %b need %b", k, anodes, exp_an); end
      n_checks++;
      if (seven_segments !== exp_seg) begin n_fail++; $display("[TB] FAIL scan_segments k=%0d: got %b need %b", k, seven_segments, exp_seg); end
      n_checks++;
      if (frame_start !== (k == 16)) begin n_fail++; $display("[TB] FAIL scan_frame_start k=%0d: got %b need %b", k, frame_start, k == 16); end
    end
  endtask

  // Mid-frame write shows next frame; a write on the wrap edge is deferred one more frame
  task automatic test_tear_free();
    logic [15:0] shown [4];
    logic [3:0]  sel;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic [15:0] val;
    int d, c;
    shown[0] = 16'h1234; shown[1] = 16'hABCD; shown[2] = 16'hABCD; shown[3] = 16'h5678;
    for (int f = 0; f < 4; f++) begin
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        val = shown[f];
        d = (k - 1) / 4;
        c = (k - 1) % 4;
        sel = 4'b0001 << d;
        exp_an  = (c == 0) ? 4'b1111 : ~sel;
        exp_seg = (c == 0) ? 7'h7F : glyph_al(val[d*4 +: 4]);
        n_checks++;
        if (anodes !== exp_an) begin n_fail++; $display("[TB] FAIL tear_anodes f=%0d k=%0d: got %b need %b", f, k, anodes, exp_an); end
        n_checks++;
        if (seven_segments !== exp_seg) begin n_fail++; $display("[TB] FAIL tear_segments f=%0d k=%0d: got %b need %b", f, k, seven_segments, exp_seg); end
        n_checks++;
        if (frame_start !== (k == 16)) begin n_fail++; $display("[TB] FAIL tear_frame_start f=%0d k=%0d: got %b need %b", f, k, frame_start, k == 16); end
        number_we = 1'b0;
        if (f == 0 && k == 5) begin number = 16'hABCD; number_we = 1'b1; end
        if (f == 1 && k == 15) begin number = 16'h5678; number_we = 1'b1; end
      end
    end
    number_we = 1'b0;
  endtask

  // Starts on a frame_start cycle with 5678 on display
  task automatic test_enable();
    logic [3:0] exp_an [6];
    logic [6:0] exp_seg [6];
    exp_an[0] = 4'b1011; exp_seg[0] = 7'h02;
    exp_an[1] = 4'b1011; exp_seg[1] = 7'h02;
    exp_an[2] = 4'b1111; exp_seg[2] = 7'h7F;
    exp_an[3] = 4'b0111; exp_seg[3] = 7'h12;
    exp_an[4] = 4'b0111; exp_seg[4] = 7'h12;
    exp_an[5] = 4'b0111; exp_seg[5] = 7'h12;
    repeat (10) @(negedge clk);
    n_checks++;
    if (anodes !== 4'b1011) begin n_fail++; $display("[TB] FAIL en_before_anodes: got %b need 1011", anodes); end
    enable = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      n_checks++;
      if (anodes !== 4'b1111) begin n_fail++; $display("[TB] FAIL en_off_anodes j=%0d: got %b need 1111", j, anodes); end
      n_checks++;
      if (seven_segments !== 7'h7F) begin n_fail++; $display("[TB] FAIL en_off_segments j=%0d: got %b need 1111111", j, seven_segments); end
      n_checks++;
      if (frame_start !== 1'b0) begin n_fail++; $display("[TB] FAIL en_off_frame_start j=%0d: got %b need 0", j, frame_start); end
    end
    enable = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      n_checks++;
      if (anodes !== exp_an[j]) begin n_fail++; $display("[TB] FAIL en_resume_anodes j=%0d: got %b need %b", j, anodes, exp_an[j]); end
      n_checks++;
      if (seven_segments !== exp_seg[j]) begin n_fail++; $display("[TB] FAIL en_resume_segments j=%0d: got %b need %b", j, seven_segments, exp_seg[j]); end
      n_checks++;
      if (frame_start !== (j == 5)) begin n_fail++; $display("[TB] FAIL en_resume_frame_start j=%0d: got %b need %b", j, frame_start, j == 5); end
    end
  endtask

`ifdef SM_HEX_DISPLAY_SCAN_LZB_EN
  task automatic test_lzb();
    logic [15:0] vals [2];
    int          top [2];
    logic [3:0]  sel;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic [15:0] val;
    bit          on;
    int d, c;
    vals[0] = 16'h0050; top[0] = 1;
    vals[1] = 16'h0000; top[1] = 0;
    for (int v = 0; v < 2; v++) begin
      number = vals[v]; dots = 4'b1000; number_we = 1'b1;
      @(negedge clk);
      number_we = 1'b0; dots = 4'b0000;
      wait_frame("lzb");
      val = vals[v];
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        d = (k - 1) / 4;
        c = (k - 1) % 4;
        on = (c != 0) && (d <= top[v]);
        sel = 4'b0001 << d;
        exp_an  = on ? ~sel : 4'b1111;
        exp_seg = on ? glyph_al(val[d*4 +: 4]) : 7'h7F;
        n_checks++;
        if (anodes !== exp_an) begin n_fail++; $display("[TB] FAIL lzb_anodes v=%0d k=%0d: got %b need %b", v, k, anodes, exp_an); end
        n_checks++;
        if (seven_segments !== exp_seg) begin n_fail++; $display("[TB] FAIL lzb_segments v=%0d k=%0d: got %b need %b", v, k, seven_segments, exp_seg); end
        n_checks++;
        if (dot !== 1'b1) begin n_fail++; $display("[TB] FAIL lzb_dot v=%0d k=%0d: got %b need 1", v, k, dot); end
      end
    end
  endtask
`else
  task automatic test_dots();
    logic [3:0]  sel;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dot;
    logic [15:0] val;
    int d, c;
    val = 16'h0050;
    number = val; dots = 4'b1000; number_we = 1'b1;
    @(negedge clk);
    number_we = 1'b0; dots = 4'b0000;
    wait_frame("dots");
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      d = (k - 1) / 4;
      c = (k - 1) % 4;
      sel = 4'b0001 << d;
      exp_an  = (c == 0) ? 4'b1111 : ~sel;
      exp_seg = (c == 0) ? 7'h7F : glyph_al(val[d*4 +: 4]);
      exp_dot = !((c != 0) && (d == 3));
      n_checks++;
      if (anodes !== exp_an) begin n_fail++; $display("[TB] FAIL dots_anodes k=%0d: got %b need %b", k, anodes, exp_an); end
      n_checks++;
      if (seven_segments !== exp_seg) begin n_fail++; $display("[TB] FAIL dots_segments k=%0d: got %b need %b", k, seven_segments, exp_seg); end
      n_checks++;
      if (dot !== exp_dot) begin n_fail++; $display("[TB] FAIL dots_dot k=%0d: got %b need %b", k, dot, exp_dot); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan_order();
    test_tear_free();
    test_enable();
`ifdef SM_HEX_DISPLAY_SCAN_LZB_EN
    test_lzb();
`else
    test_dots();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, need completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
